ap_cam_sequencer: RTL and testbench

- Command-level controller in front of one associative CAM array (cell_B, DATA_WIDTH x DATA_DEPTH).
- Accepts one operation at a time over a valid/ready command port: search, tagged toggle-write, row/column write, row/column read, copy.
- Drives the array's control pins with the cycle timing the array requires, and owns the tag register fed back to the array.
- Returns read data, match tags and error status over a valid/ready response port.

---
 rtl/ap_ctrl_pkg.sv | 31 +++
 rtl/ap_cam_sequencer.sv | 269 ++++++++++++++++++++++++++
 tb/tb_ap_cam_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ap_ctrl_pkg.sv
// Shared opcode, array-mode and FSM state encodings for the AP CAM sequencer.
package ap_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_SEARCH = 3'd1,
    OP_TOGGLE = 3'd2,
    OP_WR_ROW = 3'd3,
    OP_WR_COL = 3'd4,
    OP_RD_ROW = 3'd5,
    OP_RD_COL = 3'd6,
    OP_COPY   = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    MODE_IDLE    = 3'd0,
    MODE_ROWXROW = 3'd1,
    MODE_COLXCOL = 3'd2,
    MODE_COPY_B  = 3'd3,
    MODE_COPY_R  = 3'd4,
    MODE_COPY_A  = 3'd5
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/ap_cam_sequencer.sv
// Command-level controller for one associative CAM array (cell_B).
// Optional feature macro: AP_TAG_CHAIN_EN (AND-accumulating chained search).
module ap_cam_sequencer
  import ap_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int DATA_DEPTH     = 16,
  parameter int ADDR_WIDTH_CAM = 8,
  parameter int RD_LAT         = 3
) (
  input  logic                      clk,
  input  logic                      rstIn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [2:0]                cmd_op,
  input  logic [ADDR_WIDTH_CAM-1:0] cmd_addr,
  input  logic                      cmd_key,
  input  logic [DATA_WIDTH-1:0]     cmd_mask,
  input  logic                      cmd_chain,
  input  logic [DATA_WIDTH-1:0]     cmd_row,
  input  logic [DATA_DEPTH-1:0]     cmd_col,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_err,
  output logic [DATA_WIDTH-1:0]     rsp_row,
  output logic [DATA_DEPTH-1:0]     rsp_col,
  output logic [DATA_DEPTH-1:0]     rsp_tag,
  output logic [2:0]                cam_mode,
  output logic                      cam_rstIn,
  output logic                      cam_key,
  output logic [DATA_WIDTH-1:0]     cam_mask,
  output logic [DATA_DEPTH-1:0]     cam_tag,
  output logic [DATA_WIDTH-1:0]     cam_ip_row,
  output logic [DATA_DEPTH-1:0]     cam_ip_col,
  output logic [ADDR_WIDTH_CAM-1:0] cam_addr_in_row,
  output logic [ADDR_WIDTH_CAM-1:0] cam_addr_in_col,
  output logic [ADDR_WIDTH_CAM-1:0] cam_addr_out_row,
  output logic [ADDR_WIDTH_CAM-1:0] cam_addr_out_col,
  input  logic [DATA_DEPTH-1:0]     cam_tag_row,
  input  logic [DATA_WIDTH-1:0]     cam_q_out_row,
  input  logic [DATA_DEPTH-1:0]     cam_q_out_col
);

`ifdef AP_TAG_CHAIN_EN
  localparam logic CHAIN_EN = 1'b1;
`else
  localparam logic CHAIN_EN = 1'b0;
`endif

  localparam int CNT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 2;
  localparam logic [ADDR_WIDTH_CAM-1:0] DEPTH_A  = ADDR_WIDTH_CAM'(DATA_DEPTH);
  localparam logic [ADDR_WIDTH_CAM-1:0] WIDTH_A  = ADDR_WIDTH_CAM'(DATA_WIDTH);
  localparam logic [ADDR_WIDTH_CAM-1:0] ROW_PARK = ADDR_WIDTH_CAM'(DATA_DEPTH + 3);
  localparam logic [ADDR_WIDTH_CAM-1:0] COL_PARK = ADDR_WIDTH_CAM'(DATA_WIDTH + 3);

  state_e                    state_q, state_d;
  op_e                       op_q, op_d, cmd_op_e;
  logic                      chain_q, chain_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [DATA_DEPTH-1:0]     tag_q, tag_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0]     rsp_row_q, rsp_row_d;
  logic [DATA_DEPTH-1:0]     rsp_col_q, rsp_col_d;
  mode_e                     mode_q, mode_d;
  logic                      crst_q, crst_d;
  logic                      key_q, key_d;
  logic [DATA_WIDTH-1:0]     mask_q, mask_d;
  logic [DATA_DEPTH-1:0]     ctag_q, ctag_d;
  logic [DATA_WIDTH-1:0]     iprow_q, iprow_d;
  logic [DATA_DEPTH-1:0]     ipcol_q, ipcol_d;
  logic [ADDR_WIDTH_CAM-1:0] ainr_q, ainr_d, ainc_q, ainc_d;
  logic [ADDR_WIDTH_CAM-1:0] aoutr_q, aoutr_d, aoutc_q, aoutc_d;
  logic                      park;
  logic                      is_read;

  // Next-state and next-output computation; array pins are registered so the
  // command's drive appears exactly in the EXEC cycle after the accept edge.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    chain_d     = chain_q;
    cnt_d       = cnt_q;
    tag_d       = tag_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_row_d   = rsp_row_q;
    rsp_col_d   = rsp_col_q;
    mode_d      = mode_q;
    crst_d      = crst_q;
    key_d       = key_q;
    mask_d      = mask_q;
    ctag_d      = ctag_q;
    iprow_d     = iprow_q;
    ipcol_d     = ipcol_q;
    ainr_d      = ainr_q;
    ainc_d      = ainc_q;
    aoutr_d     = aoutr_q;
    aoutc_d     = aoutc_q;
    park        = 1'b0;
    cmd_op_e    = op_e'(cmd_op);
    is_read     = (op_q == OP_RD_ROW) || (op_q == OP_RD_COL);

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d      = cmd_op_e;
          chain_d   = cmd_chain & CHAIN_EN;
          rsp_err_d = 1'b0;
          state_d   = ST_EXEC;
          unique case (cmd_op_e)
            OP_NOP: ;
            OP_SEARCH: begin
              key_d  = cmd_key;
              mask_d = cmd_mask;
            end
            OP_TOGGLE: begin
              mask_d = cmd_mask;
              ctag_d = tag_q;
            end
            OP_WR_ROW, OP_RD_ROW: begin
              if (cmd_addr >= DEPTH_A) begin
                state_d     = ST_RESP;
                rsp_err_d   = 1'b1;
                rsp_valid_d = 1'b1;
              end else begin
                mode_d = MODE_ROWXROW;
                if (cmd_op_e == OP_WR_ROW) begin
                  crst_d  = 1'b0;
                  ainr_d  = cmd_addr;
                  iprow_d = cmd_row;
                end else begin
                  aoutr_d = cmd_addr;
                  cnt_d   = CNT_W'(RD_LAT - 1);
                end
              end
            end
            OP_WR_COL, OP_RD_COL: begin
              if (cmd_addr >= WIDTH_A) begin
                state_d     = ST_RESP;
                rsp_err_d   = 1'b1;
                rsp_valid_d = 1'b1;
              end else begin
                mode_d = MODE_COLXCOL;
                if (cmd_op_e == OP_WR_COL) begin
                  crst_d  = 1'b0;
                  ainc_d  = cmd_addr;
                  ipcol_d = cmd_col;
                end else begin
                  aoutc_d = cmd_addr;
                  cnt_d   = CNT_W'(RD_LAT - 1);
                end
              end
            end
            OP_COPY: begin
              mode_d = cmd_key ? MODE_COPY_R : MODE_COPY_A;
              crst_d = 1'b0;
            end
            default: ;
          endcase
        end
      end
      ST_EXEC, ST_WAIT: begin
        // Reads hold mode/address for RD_LAT cycles; everything else is one cycle.
        if (is_read && (cnt_q != '0)) begin
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = ST_WAIT;
        end else begin
          unique case (op_q)
            OP_SEARCH: tag_d = chain_q ? (tag_q & cam_tag_row) : cam_tag_row;
            OP_RD_ROW: rsp_row_d = cam_q_out_row;
            OP_RD_COL: rsp_col_d = cam_q_out_col;
            default: ;
          endcase
          park        = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (park) begin
      mode_d  = MODE_IDLE;
      crst_d  = 1'b1;
      key_d   = 1'b0;
      mask_d  = '0;
      ctag_d  = '0;
      iprow_d = '0;
      ipcol_d = '0;
      ainr_d  = ROW_PARK;
      ainc_d  = COL_PARK;
      aoutr_d = ROW_PARK;
      aoutc_d = COL_PARK;
    end
  end

  // State and registered outputs; reset restores the idle array drive at once.
  always_ff @(posedge clk or posedge rstIn) begin
    if (rstIn) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_NOP;
      chain_q     <= 1'b0;
      cnt_q       <= '0;
      tag_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_row_q   <= '0;
      rsp_col_q   <= '0;
      mode_q      <= MODE_IDLE;
      crst_q      <= 1'b1;
      key_q       <= 1'b0;
      mask_q      <= '0;
      ctag_q      <= '0;
      iprow_q     <= '0;
      ipcol_q     <= '0;
      ainr_q      <= ROW_PARK;
      ainc_q      <= COL_PARK;
      aoutr_q     <= ROW_PARK;
      aoutc_q     <= COL_PARK;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      chain_q     <= chain_d;
      cnt_q       <= cnt_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_row_q   <= rsp_row_d;
      rsp_col_q   <= rsp_col_d;
      mode_q      <= mode_d;
      crst_q      <= crst_d;
      key_q       <= key_d;
      mask_q      <= mask_d;
      ctag_q      <= ctag_d;
      iprow_q     <= iprow_d;
      ipcol_q     <= ipcol_d;
      ainr_q      <= ainr_d;
      ainc_q      <= ainc_d;
      aoutr_q     <= aoutr_d;
      aoutc_q     <= aoutc_d;
    end
  end

  assign cmd_ready        = (state_q == ST_IDLE);
  assign rsp_valid        = rsp_valid_q;
  assign rsp_err          = rsp_err_q;
  assign rsp_row          = rsp_row_q;
  assign rsp_col          = rsp_col_q;
  assign rsp_tag          = tag_q;
  assign cam_mode         = mode_q;
  assign cam_rstIn        = crst_q;
  assign cam_key          = key_q;
  assign cam_mask         = mask_q;
  assign cam_tag          = ctag_q;
  assign cam_ip_row       = iprow_q;
  assign cam_ip_col       = ipcol_q;
  assign cam_addr_in_row  = ainr_q;
  assign cam_addr_in_col  = ainc_q;
  assign cam_addr_out_row = aoutr_q;
  assign cam_addr_out_col = aoutc_q;

endmodule

// File: tb/tb_ap_cam_sequencer.sv
// Directed bench for ap_cam_sequencer with a behavioural cell_B array model.
module tb_ap_cam_sequencer;

  logic        clk = 1'b0;
  logic        rstIn;
  logic        cmd_valid, cmd_ready, cmd_key, cmd_chain;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_addr, cmd_mask, cmd_row;
  logic [15:0] cmd_col;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [7:0]  rsp_row;
  logic [15:0] rsp_col, rsp_tag;
  logic [2:0]  cam_mode;
  logic        cam_rstIn, cam_key;
  logic [7:0]  cam_mask, cam_ip_row;
  logic [15:0] cam_tag, cam_ip_col;
  logic [7:0]  cam_addr_in_row, cam_addr_in_col, cam_addr_out_row, cam_addr_out_col;
  logic [15:0] cam_tag_row, cam_q_out_col;
  logic [7:0]  cam_q_out_row;

  int total = 0;
  int bad   = 0;

  // Observations made by do_cmd in the EXEC cycle and on response.
  int          lat;
  logic [2:0]  m_exec;
  logic        r_exec, rdy_exec;
  logic [15:0] t_exec;

  always #5 clk = ~clk;

  ap_cam_sequencer #(
    .DATA_WIDTH(8), .DATA_DEPTH(16), .ADDR_WIDTH_CAM(8), .RD_LAT(3)
  ) dut (
    .clk(clk), .rstIn(rstIn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_key(cmd_key), .cmd_mask(cmd_mask), .cmd_chain(cmd_chain), .cmd_row(cmd_row),
    .cmd_col(cmd_col), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err),
    .rsp_row(rsp_row), .rsp_col(rsp_col), .rsp_tag(rsp_tag), .cam_mode(cam_mode),
    .cam_rstIn(cam_rstIn), .cam_key(cam_key), .cam_mask(cam_mask), .cam_tag(cam_tag),
    .cam_ip_row(cam_ip_row), .cam_ip_col(cam_ip_col),
    .cam_addr_in_row(cam_addr_in_row), .cam_addr_in_col(cam_addr_in_col),
    .cam_addr_out_row(cam_addr_out_row), .cam_addr_out_col(cam_addr_out_col),
    .cam_tag_row(cam_tag_row), .cam_q_out_row(cam_q_out_row), .cam_q_out_col(cam_q_out_col)
  );

  // Array model: combinational match lines, edge-triggered write/toggle,
  // two-register read path so Q_out is valid on the third read cycle.
  logic [7:0]  mem [16];
  logic [7:0]  q1_row;
  logic [15:0] q1_col;

  always_comb begin
    cam_tag_row = '0;
    for (int r = 0; r < 16; r++)
      cam_tag_row[r] = (((mem[r] ^ {8{cam_key}}) & cam_mask) == 8'h00);
  end

  always @(posedge clk) begin
    if (cam_mode == 3'd0) begin
      for (int r = 0; r < 16; r++) if (cam_tag[r]) mem[r] <= mem[r] ^ cam_mask;
    end else if (cam_mode == 3'd1 && !cam_rstIn && cam_addr_in_row < 8'd16) begin
      mem[cam_addr_in_row[3:0]] <= cam_ip_row;
    end else if (cam_mode == 3'd2 && !cam_rstIn && cam_addr_in_col < 8'd8) begin
      for (int r = 0; r < 16; r++) mem[r][cam_addr_in_col[2:0]] <= cam_ip_col[r];
    end
    q1_row <= (cam_addr_out_row < 8'd16) ? mem[cam_addr_out_row[3:0]] : 8'h00;
    for (int r = 0; r < 16; r++)
      q1_col[r] <= (cam_addr_out_col < 8'd8) ? mem[r][cam_addr_out_col[2:0]] : 1'b0;
    cam_q_out_row <= q1_row;
    cam_q_out_col <= q1_col;
  end

  task automatic do_cmd(input logic [2:0] op, input logic [7:0] addr, input logic key,
                        input logic [7:0] mask, input logic chain, input logic [7:0] row,
                        input logic [15:0] col);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_key = key;
    cmd_mask = mask; cmd_chain = chain; cmd_row = row; cmd_col = col;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    m_exec = cam_mode; r_exec = cam_rstIn; t_exec = cam_tag; rdy_exec = cmd_ready;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    total++;
    if (!rsp_valid) begin bad++; $display("FAIL rsp_timeout op=%0d got=0 exp=1", op); end
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", cmd_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", rsp_valid); end
    total++; if (cam_mode !== 3'd0 || cam_rstIn !== 1'b1 || cam_mask !== 8'h00 || cam_tag !== 16'h0)
      begin bad++; $display("FAIL rst_cam mode=%0d rst=%b mask=%h tag=%h exp 0/1/00/0000", cam_mode, cam_rstIn, cam_mask, cam_tag); end
    total++; if (cam_addr_out_row !== 8'd19 || cam_addr_out_col !== 8'd11 || cam_addr_in_row !== 8'd19 || cam_addr_in_col !== 8'd11)
      begin bad++; $display("FAIL rst_park got=%0d/%0d/%0d/%0d exp=19/11/19/11", cam_addr_out_row, cam_addr_out_col, cam_addr_in_row, cam_addr_in_col); end
    total++; if (rsp_tag !== 16'h0 || rsp_row !== 8'h0 || rsp_err !== 1'b0)
      begin bad++; $display("FAIL rst_rsp tag=%h row=%h err=%b exp=0", rsp_tag, rsp_row, rsp_err); end
  endtask

  task automatic test_wr_rd_row();
    do_cmd(3'd3, 8'd5, 1'b0, 8'h00, 1'b0, 8'hA5, 16'h0);
    total++; if (lat != 2) begin bad++; $display("FAIL wr_lat got=%0d exp=2", lat); end
    total++; if (m_exec !== 3'd1 || r_exec !== 1'b0 || rdy_exec !== 1'b0)
      begin bad++; $display("FAIL wr_exec mode=%0d rst=%b rdy=%b exp=1/0/0", m_exec, r_exec, rdy_exec); end
    take_rsp();
    do_cmd(3'd5, 8'd5, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0);
    total++; if (lat != 4) begin bad++; $display("FAIL rd_lat got=%0d exp=4", lat); end
    total++; if (rsp_row !== 8'hA5 || rsp_err !== 1'b0) begin bad++; $display("FAIL rd_row5 got=%h/%b exp=a5/0", rsp_row, rsp_err); end
    total++; if (m_exec !== 3'd1 || r_exec !== 1'b1) begin bad++; $display("FAIL rd_exec mode=%0d rst=%b exp=1/1", m_exec, r_exec); end
    take_rsp();
  endtask

  task automatic test_col();
    for (int i = 0; i < 16; i++) begin
      do_cmd(3'd3, 8'(i), 1'b0, 8'h00, 1'b0, 8'(i), 16'h0); take_rsp();
    end
    do_cmd(3'd4, 8'd0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
    total++; if (m_exec !== 3'd2 || r_exec !== 1'b0) begin bad++; $display("FAIL wrcol_exec mode=%0d rst=%b exp=2/0", m_exec, r_exec); end
    take_rsp();
    do_cmd(3'd6, 8'd1, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0);
    total++; if (rsp_col !== 16'hCCCC || lat != 4) begin bad++; $display("FAIL rd_col1 got=%h lat=%0d exp=cccc lat=4", rsp_col, lat); end
    take_rsp();
    do_cmd(3'd5, 8'd3, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0);
    total++; if (rsp_row !== 8'h02) begin bad++; $display("FAIL rd_row3 got=%h exp=02", rsp_row); end
    take_rsp();
  endtask

  task automatic test_search_toggle();
    for (int i = 0; i < 16; i++) begin
      do_cmd(3'd3, 8'(i), 1'b0, 8'h00, 1'b0, (i == 2) ? 8'hFF : 8'h00, 16'h0); take_rsp();
    end
    do_cmd(3'd1, 8'd0, 1'b1, 8'h0F, 1'b0, 8'h00, 16'h0);
    total++; if (rsp_tag !== 16'h0004 || lat != 2) begin bad++; $display("FAIL search got=%h lat=%0d exp=0004 lat=2", rsp_tag, lat); end
    total++; if (t_exec !== 16'h0 || m_exec !== 3'd0) begin bad++; $display("FAIL search_exec tag=%h mode=%0d exp=0000/0", t_exec, m_exec); end
    take_rsp();
    do_cmd(3'd2, 8'd0, 1'b0, 8'h01, 1'b0, 8'h00, 16'h0);
    total++; if (t_exec !== 16'h0004 || m_exec !== 3'd0) begin bad++; $display("FAIL toggle_exec tag=%h mode=%0d exp=0004/0", t_exec, m_exec); end
    total++; if (cam_tag !== 16'h0) begin bad++; $display("FAIL toggle_after tag=%h exp=0000", cam_tag); end
    take_rsp();
    do_cmd(3'd5, 8'd3, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0);
    total++; if (rsp_row !== 8'h00) begin bad++; $display("FAIL rd_row3b got=%h exp=00", rsp_row); end
    take_rsp();
    do_cmd(3'd5, 8'd2, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0);
    total++; if (rsp_row !== 8'hFE) begin bad++; $display("FAIL rd_row2 got=%h exp=fe", rsp_row); end
    take_rsp();
    do_cmd(3'd0, 8'd0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0);
    total++; if (rsp_row !== 8'hFE || lat != 2 || m_exec !== 3'd0)
      begin bad++; $display("FAIL nop got row=%h lat=%0d mode=%0d exp=fe/2/0", rsp_row, lat, m_exec); end
    take_rsp();
  endtask

  task automatic test_err();
    do_cmd(3'd5, 8'd16, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0);
    total++; if (rsp_err !== 1'b1 || m_exec !== 3'd0) begin bad++; $display("FAIL err_row got=%b mode=%0d exp=1/0", rsp_err, m_exec); end
    total++; if (rsp_tag !== 16'h0004) begin bad++; $display("FAIL err_tag got=%h exp=0004", rsp_tag); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_tag !== 16'h0004 || rsp_row !== 8'hFE || cam_mode !== 3'd0)
        begin bad++; $display("FAIL err_hold c=%0d got=%b/%b/%h/%h/%0d exp=1/1/0004/fe/0", c, rsp_valid, rsp_err, rsp_tag, rsp_row, cam_mode); end
    end
    take_rsp();
    do_cmd(3'd4, 8'd8, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0);
    total++; if (rsp_err !== 1'b1 || r_exec !== 1'b1) begin bad++; $display("FAIL err_col got=%b rst=%b exp=1/1", rsp_err, r_exec); end
    take_rsp();
    do_cmd(3'd3, 8'd15, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0);
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", rsp_err); end
    take_rsp();
  endtask

  task automatic test_chain();
    for (int i = 0; i < 16; i++) begin
      do_cmd(3'd3, 8'(i), 1'b0, 8'h00, 1'b0, (i == 1 || i == 3) ? 8'(i) : 8'(i & 2), 16'h0); take_rsp();
    end
    do_cmd(3'd1, 8'd0, 1'b1, 8'h01, 1'b0, 8'h00, 16'h0);
    total++; if (rsp_tag !== 16'h000A) begin bad++; $display("FAIL chain_first got=%h exp=000a", rsp_tag); end
    take_rsp();
    do_cmd(3'd1, 8'd0, 1'b0, 8'h02, 1'b1, 8'h00, 16'h0);
`ifdef AP_TAG_CHAIN_EN
    total++; if (rsp_tag !== 16'h0002) begin bad++; $display("FAIL chain_second got=%h exp=0002", rsp_tag); end
`else
    total++; if (rsp_tag !== 16'h3333) begin bad++; $display("FAIL chain_second got=%h exp=3333", rsp_tag); end
`endif
    take_rsp();
  endtask

  task automatic test_copy();
    do_cmd(3'd7, 8'd0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0);
    total++; if (m_exec !== 3'd5 || r_exec !== 1'b0 || lat != 2) begin bad++; $display("FAIL copy_a mode=%0d rst=%b lat=%0d exp=5/0/2", m_exec, r_exec, lat); end
    take_rsp();
    do_cmd(3'd7, 8'd0, 1'b1, 8'h00, 1'b0, 8'h00, 16'h0);
    total++; if (m_exec !== 3'd4 || r_exec !== 1'b0) begin bad++; $display("FAIL copy_r mode=%0d rst=%b exp=4/0", m_exec, r_exec); end
    total++; if (cam_mode !== 3'd0 || cam_rstIn !== 1'b1) begin bad++; $display("FAIL copy_after mode=%0d rst=%b exp=0/1", cam_mode, cam_rstIn); end
    take_rsp();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd5; cmd_addr = 8'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    total++; if (cam_mode !== 3'd1) begin bad++; $display("FAIL mid_wait mode=%0d exp=1", cam_mode); end
    rstIn = 1'b1;
    #1;
    total++; if (cam_mode !== 3'd0 || cam_rstIn !== 1'b1 || rsp_valid !== 1'b0 || cam_addr_out_row !== 8'd19)
      begin bad++; $display("FAIL mid_async got=%0d/%b/%b/%0d exp=0/1/0/19", cam_mode, cam_rstIn, rsp_valid, cam_addr_out_row); end
    @(negedge clk);
    rstIn = 1'b0;
    #1;
    total++; if (cmd_ready !== 1'b1 || rsp_tag !== 16'h0) begin bad++; $display("FAIL mid_release rdy=%b tag=%h exp=1/0000", cmd_ready, rsp_tag); end
    repeat (4) @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_dropped got=%b exp=0", rsp_valid); end
    do_cmd(3'd5, 8'd3, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0);
    total++; if (rsp_row !== 8'h03) begin bad++; $display("FAIL mid_contents got=%h exp=03", rsp_row); end
    take_rsp();
  endtask

  initial begin
    rstIn = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_op = 3'd0; cmd_addr = 8'd0;
    cmd_key = 1'b0; cmd_mask = 8'h00; cmd_chain = 1'b0; cmd_row = 8'h00; cmd_col = 16'h0;
    repeat (3) @(negedge clk);
    test_reset();
    rstIn = 1'b0;
    test_wr_rd_row();
    test_col();
    test_search_toggle();
    test_err();
    test_chain();
    test_copy();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
